// File: rtl/comparator_serial_cascade_if.sv
// Bus bundle between operand producer/result consumer, the external 2-bit
// comparator and the serial cascade controller.
`timescale 1ns/1ps
interface comparator_serial_cascade_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned NUM_SLICES = DATA_WIDTH / 2;
    localparam int unsigned SU_W       = $clog2(NUM_SLICES) + 1;

    logic                  Start_In;
    logic [DATA_WIDTH-1:0] Data_A_In;
    logic [DATA_WIDTH-1:0] Data_B_In;
    logic                  Slice_Enable_Out;
    logic [1:0]            Slice_A_Out;
    logic [1:0]            Slice_B_Out;
    logic                  Slice_gt_In;
    logic                  Slice_eq_In;
    logic                  Slice_lt_In;
    logic                  Busy_Out;
    logic                  Done_Out;
    logic                  A_gt_B_Out;
    logic                  A_eq_B_Out;
    logic                  A_lt_B_Out;
    logic                  Error_Out;
    logic [SU_W-1:0]       Slices_Used_Out;

    // Controller side
    modport slave (
        input  Start_In, Data_A_In, Data_B_In,
        input  Slice_gt_In, Slice_eq_In, Slice_lt_In,
        output Slice_Enable_Out, Slice_A_Out, Slice_B_Out,
        output Busy_Out, Done_Out, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out,
        output Error_Out, Slices_Used_Out
    );

    // Producer / comparator / consumer side
    modport master (
        output Start_In, Data_A_In, Data_B_In,
        output Slice_gt_In, Slice_eq_In, Slice_lt_In,
        input  Slice_Enable_Out, Slice_A_Out, Slice_B_Out,
        input  Busy_Out, Done_Out, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out,
        input  Error_Out, Slices_Used_Out
    );
endinterface

// File: rtl/comparator_serial_cascade.sv
// Wide magnitude comparator that walks 2-bit slices MSB-first through one
// external 2-bit comparator, stopping on the first unequal slice.
`timescale 1ns/1ps
module comparator_serial_cascade #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    comparator_serial_cascade_if.slave    bus
);
    localparam int unsigned NUM_SLICES = DATA_WIDTH / 2;
    localparam int unsigned K_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int unsigned SU_W       = $clog2(NUM_SLICES) + 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COMPARE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [K_W-1:0]        r_k;
    logic [SU_W-1:0]       r_used;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_slice_a;
    logic [1:0]            r_slice_b;
    logic                  r_gt;
    logic                  r_eq;
    logic                  r_lt;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_advance;
    logic                  w_finish;
    logic                  w_res_gt;
    logic                  w_res_eq;
    logic                  w_res_lt;
    logic                  w_res_err;
    logic [K_W-1:0]        w_k_dec;
    logic [1:0]            w_slice_a_nxt;
    logic [1:0]            w_slice_b_nxt;

    // State register
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-edge decisions from the sampled comparator flags
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_res_gt    = 1'b0;
        w_res_eq    = 1'b0;
        w_res_lt    = 1'b0;
        w_res_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start_In) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                // Exact-match case: X/Z or multi-hot flags fall to the error arm
                case ({bus.Slice_gt_In, bus.Slice_eq_In, bus.Slice_lt_In})
                    3'b100: begin
                        w_finish = 1'b1;
                        w_res_gt = 1'b1;
                    end
                    3'b001: begin
                        w_finish = 1'b1;
                        w_res_lt = 1'b1;
                    end
                    3'b010: begin
                        if (r_k == '0) begin
                            w_finish = 1'b1;
                            w_res_eq = 1'b1;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                    default: begin
                        w_finish  = 1'b1;
                        w_res_err = 1'b1;
                    end
                endcase
                if (w_finish) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next slice to present once the current one compares equal
    always_comb begin
        w_k_dec       = r_k - K_W'(1);
        w_slice_a_nxt = 2'(r_a >> {w_k_dec, 1'b0});
        w_slice_b_nxt = 2'(r_b >> {w_k_dec, 1'b0});
    end

    // Operand latches, slice presentation and registered results
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_used    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_slice_a <= 2'b00;
            r_slice_b <= 2'b00;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_a       <= bus.Data_A_In;
                r_b       <= bus.Data_B_In;
                r_k       <= K_W'(NUM_SLICES - 1);
                r_used    <= '0;
                r_busy    <= 1'b1;
                r_slice_a <= bus.Data_A_In[DATA_WIDTH-1 -: 2];
                r_slice_b <= bus.Data_B_In[DATA_WIDTH-1 -: 2];
                r_gt      <= 1'b0;
                r_eq      <= 1'b0;
                r_lt      <= 1'b0;
                r_err     <= 1'b0;
            end
            if (r_state == ST_COMPARE) begin
                r_used <= r_used + SU_W'(1);
            end
            if (w_advance) begin
                r_k       <= w_k_dec;
                r_slice_a <= w_slice_a_nxt;
                r_slice_b <= w_slice_b_nxt;
            end
            if (w_finish) begin
                r_busy    <= 1'b0;
                r_slice_a <= 2'b00;
                r_slice_b <= 2'b00;
                r_gt      <= w_res_gt;
                r_eq      <= w_res_eq;
                r_lt      <= w_res_lt;
                r_err     <= w_res_err;
            end
        end
    end

    assign bus.Slice_Enable_Out = r_busy;
    assign bus.Busy_Out         = r_busy;
    assign bus.Done_Out         = r_done;
    assign bus.Slice_A_Out      = r_slice_a;
    assign bus.Slice_B_Out      = r_slice_b;
    assign bus.A_gt_B_Out       = r_gt;
    assign bus.A_eq_B_Out       = r_eq;
    assign bus.A_lt_B_Out       = r_lt;
    assign bus.Error_Out        = r_err;
    assign bus.Slices_Used_Out  = r_used;

endmodule

// File: tb/tb_comparator_serial_cascade.sv
// Bench for the serial slice comparator: behavioural 2-bit comparator with
// fault injection, directed scenarios and a randomized run against a model.
`timescale 1ns/1ps
module tb_comparator_serial_cascade;
    localparam int DW = 8;
    localparam int NS = DW / 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   fault_kind;   // 0 none, 1 gt=eq=1, 2 all flags low (on second slice)
    int   cyc;
    logic [1:0] pa [16];
    logic [1:0] pb [16];

    comparator_serial_cascade_if #(.DATA_WIDTH(DW)) bus ();

    comparator_serial_cascade #(.DATA_WIDTH(DW)) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles spent in COMPARE so faults can target a specific slice
    always @(posedge clk) cyc <= bus.Busy_Out ? cyc + 1 : 0;

    // Behavioural external 2-bit comparator
    always_comb begin
        bus.Slice_gt_In = 1'b0;
        bus.Slice_eq_In = 1'b0;
        bus.Slice_lt_In = 1'b0;
        if (bus.Slice_Enable_Out) begin
            bus.Slice_gt_In = (bus.Slice_A_Out > bus.Slice_B_Out);
            bus.Slice_eq_In = (bus.Slice_A_Out == bus.Slice_B_Out);
            bus.Slice_lt_In = (bus.Slice_A_Out < bus.Slice_B_Out);
            if (fault_kind == 1 && cyc == 1) begin
                bus.Slice_gt_In = 1'b1;
                bus.Slice_eq_In = 1'b1;
                bus.Slice_lt_In = 1'b0;
            end else if (fault_kind == 2 && cyc == 1) begin
                bus.Slice_gt_In = 1'b0;
                bus.Slice_eq_In = 1'b0;
                bus.Slice_lt_In = 1'b0;
            end
        end
    end

    // Model: slices examined = slices down to and including the highest differing one
    function automatic int model_used(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] d;
        int hi;
        d  = a ^ b;
        hi = -1;
        for (int i = 0; i < DW; i++) if (d[i]) hi = i;
        return (hi < 0) ? NS : NS - hi / 2;
    endfunction

    function automatic logic [1:0] model_slice(input logic [DW-1:0] v, input int j);
        logic [DW-1:0] s;
        s = v >> (2 * (NS - 1 - j));
        return s[1:0];
    endfunction

    function automatic logic [13:0] all_outs();
        return {bus.Busy_Out, bus.Done_Out, bus.Slice_Enable_Out, bus.Slice_A_Out,
                bus.Slice_B_Out, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out,
                bus.Error_Out, bus.Slices_Used_Out};
    endfunction

    // Present a start pulse at the next edge; returns at the negedge after it
    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        @(posedge clk);
        @(negedge clk);
        bus.Start_In = 1'b0;
    endtask

    // Wait for Done, recording presented slices per cycle
    task automatic wait_done(input int budget, output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b1;
        while (lat < budget) begin
            if (lat < 16) begin
                pa[lat] = bus.Slice_A_Out;
                pb[lat] = bus.Slice_B_Out;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.Done_Out) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (all_outs() !== 14'd0) begin
            $display("FAIL reset_hold: outs=%h want 0", all_outs());
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== 14'd0) begin
            $display("FAIL reset_release: outs=%h want 0", all_outs());
            errors++;
        end
    endtask

    task automatic test_msb_decides();
        int lat; bit to;
        start_op(8'hC0, 8'h3F);
        checks++;
        if ({bus.Busy_Out, bus.Slice_Enable_Out, bus.Slice_A_Out, bus.Slice_B_Out} !== {1'b1, 1'b1, 2'd3, 2'd0}) begin
            $display("FAIL msb_present: busy/en/sa/sb=%b%b %0d/%0d want 11 3/0",
                     bus.Busy_Out, bus.Slice_Enable_Out, bus.Slice_A_Out, bus.Slice_B_Out);
            errors++;
        end
        wait_done(20, lat, to);
        checks++;
        if (to || lat != 1) begin
            $display("FAIL msb_latency: lat=%0d timeout=%0d want 1", lat, to);
            errors++;
        end
        checks++;
        if ({bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out} !== {4'b1000, 3'd1}) begin
            $display("FAIL msb_result: gel/err/used=%b%b%b %b %0d want 100 0 1",
                     bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out);
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({bus.Done_Out, bus.Busy_Out, bus.A_gt_B_Out, bus.Slices_Used_Out} !== {3'b001, 3'd1}) begin
            $display("FAIL msb_hold: done/busy/gt/used=%b%b%b %0d want 001 1",
                     bus.Done_Out, bus.Busy_Out, bus.A_gt_B_Out, bus.Slices_Used_Out);
            errors++;
        end
    endtask

    task automatic test_equal();
        int lat; bit to;
        logic [7:0] seen, want;
        start_op(8'h5A, 8'h5A);
        wait_done(20, lat, to);
        seen = {pa[0], pa[1], pa[2], pa[3]};
        want = 8'b01_01_10_10;
        checks++;
        if (seen !== want || {pb[0], pb[1], pb[2], pb[3]} !== want) begin
            $display("FAIL eq_slices: a=%b b=%b want %b", seen, {pb[0], pb[1], pb[2], pb[3]}, want);
            errors++;
        end
        checks++;
        if (to || lat != 4) begin
            $display("FAIL eq_latency: lat=%0d timeout=%0d want 4", lat, to);
            errors++;
        end
        checks++;
        if ({bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out} !== {4'b0100, 3'd4}) begin
            $display("FAIL eq_result: gel/err/used=%b%b%b %b %0d want 010 0 4",
                     bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit to;
        start_op(8'h12, 8'h13);
        wait_done(20, lat, to);
        checks++;
        if (to || lat != 4 || {bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out} !== {3'b001, 3'd4}) begin
            $display("FAIL b2b_first: lat=%0d gel=%b%b%b used=%0d want 4 001 4",
                     lat, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out);
            errors++;
        end
        start_op(8'h13, 8'h12);
        checks++;
        if (bus.Busy_Out !== 1'b1 || bus.A_lt_B_Out !== 1'b0) begin
            $display("FAIL b2b_accept: busy=%b lt=%b want 1 0", bus.Busy_Out, bus.A_lt_B_Out);
            errors++;
        end
        wait_done(20, lat, to);
        checks++;
        if (to || lat != 4 || {bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out} !== {3'b100, 3'd4}) begin
            $display("FAIL b2b_second: lat=%0d gel=%b%b%b used=%0d want 4 100 4",
                     lat, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        int lat; bit to;
        for (int k = 1; k <= 2; k++) begin
            fault_kind = k;
            start_op(8'h5A, 8'h5A);
            wait_done(20, lat, to);
            fault_kind = 0;
            checks++;
            if (to || lat != 2 || {bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out} !== {4'b0001, 3'd2}) begin
                $display("FAIL error_kind%0d: lat=%0d gel=%b%b%b err=%b used=%0d want 2 000 1 2",
                         k, lat, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out);
                errors++;
            end
            @(negedge clk);
        end
        start_op(8'h40, 8'h80);
        wait_done(20, lat, to);
        checks++;
        if (to || {bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out} !== {2'b10, 3'd1}) begin
            $display("FAIL error_clear: lt=%b err=%b used=%0d want 1 0 1",
                     bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int lat; bit to;
        start_op(8'h5A, 8'h5A);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = 8'h00;
        bus.Data_B_In = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.Start_In = 1'b0;
        wait_done(20, lat, to);
        checks++;
        if (to || lat != 3 || {bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out} !== {3'b010, 3'd4}) begin
            $display("FAIL busy_ignore: lat=%0d gel=%b%b%b used=%0d want 3 010 4",
                     lat, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out);
            errors++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Busy_Out !== 1'b0 || bus.A_eq_B_Out !== 1'b1) begin
            $display("FAIL busy_noqueue: busy=%b eq=%b want 0 1", bus.Busy_Out, bus.A_eq_B_Out);
            errors++;
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit to;
        bit saw_done;
        start_op(8'h5A, 8'h5A);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 14'd0) begin
            $display("FAIL abort_outs: outs=%h want 0", all_outs());
            errors++;
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.Done_Out) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.Done_Out) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || all_outs() !== 14'd0) begin
            $display("FAIL abort_nodone: done_seen=%b outs=%h want 0 0", saw_done, all_outs());
            errors++;
        end
        start_op(8'hA7, 8'hA4);
        wait_done(20, lat, to);
        checks++;
        if (to || lat != 4 || {bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out} !== {3'b100, 3'd4}) begin
            $display("FAIL abort_recover: lat=%0d gel=%b%b%b used=%0d want 4 100 4",
                     lat, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Slices_Used_Out);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat; bit to;
        logic [DW-1:0] a, b;
        int used;
        bit slice_bad;
        logic [2:0] want_res;
        for (int n = 0; n < 60; n++) begin
            a = DW'($urandom);
            case ($urandom_range(0, 3))
                0: b = DW'($urandom);
                1: b = a;
                2: b = a ^ DW'(1 << $urandom_range(0, DW - 1));
                default: b = a ^ DW'($urandom_range(1, 15));
            endcase
            used     = model_used(a, b);
            want_res = {a > b, a == b, a < b};
            start_op(a, b);
            wait_done(20, lat, to);
            checks++;
            if (to || lat != used) begin
                $display("FAIL rand_latency: a=%h b=%h lat=%0d timeout=%0d want %0d", a, b, lat, to, used);
                errors++;
            end
            checks++;
            if ({bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out, bus.Slices_Used_Out} !== {want_res, 1'b0, 3'(used)}) begin
                $display("FAIL rand_result: a=%h b=%h gel=%b%b%b err=%b used=%0d want %b 0 %0d",
                         a, b, bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out, bus.Error_Out,
                         bus.Slices_Used_Out, want_res, used);
                errors++;
            end
            slice_bad = 1'b0;
            for (int j = 0; j < used && j < lat; j++)
                if (pa[j] !== model_slice(a, j) || pb[j] !== model_slice(b, j)) slice_bad = 1'b1;
            checks++;
            if (slice_bad) begin
                $display("FAIL rand_slices: a=%h b=%h first presented %0d/%0d", a, b, pa[0], pb[0]);
                errors++;
            end
            // Either issue the next start in the Done cycle or idle a little
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        fault_kind    = 0;
        rst           = 1'b1;
        bus.Start_In  = 1'b0;
        bus.Data_A_In = '0;
        bus.Data_B_In = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_msb_decides();
        test_equal();
        test_back_to_back();
        test_error();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
